// File: rtl/instr_seq.sv
`default_nettype none
// ============================================================================
// instr_seq : program sequencer for the instruction memory; optional command
//             watchdog enabled by INSTR_SEQ_WDOG_EN.          Revision 1.0
// ============================================================================
module instr_seq #(
    parameter int WIDTH_INSTR  = 32,
    parameter int WIDTH_OPCODE = 4,
    parameter int WIDTH_JDATA  = 24,
    parameter int WIDTH_ADDR   = 8,
    parameter int WIDTH_LOOP   = 16,
    parameter int MEM_LAT      = 2,
    parameter int WDOG_W       = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [WIDTH_INSTR-1:0]  instr,
    output logic                    next_instr,
    output logic                    jump,
    output logic [WIDTH_OPCODE-1:0] opcode,
    output logic [WIDTH_JDATA-1:0]  jdata,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [WIDTH_JDATA-1:0]  cmd_data,
    output logic                    busy,
    output logic                    halted,
    output logic                    error
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);

    localparam logic [WIDTH_OPCODE-1:0] OP_NOP  = WIDTH_OPCODE'(4'b0000);
    localparam logic [WIDTH_OPCODE-1:0] OP_CMD  = WIDTH_OPCODE'(4'b0001);
    localparam logic [WIDTH_OPCODE-1:0] OP_WAIT = WIDTH_OPCODE'(4'b0010);
    localparam logic [WIDTH_OPCODE-1:0] OP_LOOP = WIDTH_OPCODE'(4'b0011);
    localparam logic [WIDTH_OPCODE-1:0] OP_DJNZ = WIDTH_OPCODE'(4'b1001);
    localparam logic [WIDTH_OPCODE-1:0] OP_JMP  = WIDTH_OPCODE'(4'b1010);
    localparam logic [WIDTH_OPCODE-1:0] OP_HALT = WIDTH_OPCODE'(4'b1111);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_CMD, S_WAIT, S_HALT
    } state_t;

    state_t                  state, state_nx;
    logic [WIDTH_OPCODE-1:0] ir_op, ir_op_nx;
    logic [WIDTH_JDATA-1:0]  ir_jd, ir_jd_nx;
    logic [WIDTH_JDATA-1:0]  wait_cnt, wait_nx;
    logic [WIDTH_LOOP-1:0]   loop_cnt, loop_nx;
    logic [LAT_W-1:0]        lat_cnt, lat_nx;
    logic                    error_nx;
    logic                    go_fetch;
    logic                    wdog_trip;
    logic                    unused_bits;

    assign opcode   = ir_op;
    assign jdata    = ir_jd;
    assign cmd_data = ir_jd;
    assign busy     = (state != S_IDLE) && (state != S_HALT);
    assign halted   = (state == S_HALT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            ir_op    <= '0;
            ir_jd    <= '0;
            wait_cnt <= '0;
            loop_cnt <= '0;
            lat_cnt  <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_nx;
            ir_op    <= ir_op_nx;
            ir_jd    <= ir_jd_nx;
            wait_cnt <= wait_nx;
            loop_cnt <= loop_nx;
            lat_cnt  <= lat_nx;
            error    <= error_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ir_op_nx   = ir_op;
        ir_jd_nx   = ir_jd;
        wait_nx    = wait_cnt;
        loop_nx    = loop_cnt;
        lat_nx     = lat_cnt;
        error_nx   = error;
        go_fetch   = 1'b0;
        next_instr = 1'b0;
        jump       = 1'b0;
        cmd_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                // The first fetch reads address 0 directly, so no pulse here.
                if (start) go_fetch = 1'b1;
            end
            S_FETCH: begin
                lat_nx = lat_cnt - LAT_W'(1);
                if (lat_cnt <= LAT_W'(1)) state_nx = S_DECODE;
            end
            S_DECODE: begin
                ir_op_nx = instr[WIDTH_INSTR-1 -: WIDTH_OPCODE];
                ir_jd_nx = instr[WIDTH_JDATA-1:0];
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                case (ir_op)
                    OP_NOP: begin
                        next_instr = 1'b1;
                        go_fetch   = 1'b1;
                    end
                    OP_CMD: state_nx = S_CMD;
                    OP_WAIT: begin
                        if (ir_jd == '0) begin
                            next_instr = 1'b1;
                            go_fetch   = 1'b1;
                        end else begin
                            wait_nx  = ir_jd;
                            state_nx = S_WAIT;
                        end
                    end
                    OP_LOOP: begin
                        loop_nx    = ir_jd[WIDTH_LOOP-1:0];
                        next_instr = 1'b1;
                        go_fetch   = 1'b1;
                    end
                    OP_DJNZ: begin
                        if (loop_cnt > WIDTH_LOOP'(1)) begin
                            loop_nx = loop_cnt - WIDTH_LOOP'(1);
                            jump    = 1'b1;
                        end else begin
                            loop_nx    = '0;
                            next_instr = 1'b1;
                        end
                        go_fetch = 1'b1;
                    end
                    OP_JMP: begin
                        jump     = 1'b1;
                        go_fetch = 1'b1;
                    end
                    OP_HALT: state_nx = S_HALT;
                    default: begin
                        error_nx = 1'b1;
                        state_nx = S_HALT;
                    end
                endcase
            end
            S_CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    next_instr = 1'b1;
                    go_fetch   = 1'b1;
                end else if (wdog_trip) begin
                    error_nx = 1'b1;
                    state_nx = S_HALT;
                end
            end
            S_WAIT: begin
                wait_nx = wait_cnt - WIDTH_JDATA'(1);
                if (wait_cnt <= WIDTH_JDATA'(1)) begin
                    next_instr = 1'b1;
                    go_fetch   = 1'b1;
                end
            end
            S_HALT: begin
                // Resume skips the halting word (or a stalled command).
                if (start) begin
                    error_nx   = 1'b0;
                    next_instr = 1'b1;
                    go_fetch   = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (go_fetch) begin
            state_nx = S_FETCH;
            lat_nx   = LAT_INIT;
        end
    end

`ifdef INSTR_SEQ_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((1 << WDOG_W) - 2);
    logic [WDOG_W-1:0] wdog;

    // Trips on the stall that would bring the count to all-ones.
    assign wdog_trip = (state == S_CMD) && !cmd_ready && (wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (!rstn || state != S_CMD || cmd_ready || wdog_trip) wdog <= '0;
        else wdog <= wdog + WDOG_W'(1);
    end

    assign unused_bits = ^{instr, 32'(WIDTH_ADDR)};
`else
    assign wdog_trip   = 1'b0;
    assign unused_bits = ^{instr, 32'(WIDTH_ADDR), 32'(WDOG_W)};
`endif

endmodule
`default_nettype wire

// File: doc/instr_seq.md
Name: instr_seq

Overview:
- Program sequencer for the instruction memory.
- Drives the memory's address-control inputs (next_instr, jump, opcode, jdata) and captures each fetched instruction word.
- Executes control opcodes (jump, loop, wait, halt) itself; forwards command words to the datapath over a valid/ready handshake.
- Sits between the instruction memory and the datapath command consumer.

Parameters:
WIDTH_INSTR, 32, instruction word width
WIDTH_OPCODE, 4, opcode field width, instr[WIDTH_INSTR-1 -: WIDTH_OPCODE]
WIDTH_JDATA, 24, operand field width, instr[WIDTH_JDATA-1:0]
WIDTH_ADDR, 8, memory address width; relative offset = jdata[WIDTH_ADDR-1:0]
WIDTH_LOOP, 16, loop counter width; loaded from jdata[WIDTH_LOOP-1:0]
MEM_LAT, 2, cycles from an address-control pulse to a valid instr
WDOG_W, 8, watchdog counter width (optional feature only)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  reset; synchronous, active-low
start  in  1  start/resume pulse
instr  in  WIDTH_INSTR  word from instruction memory
next_instr  out  1  advance address by 1, one-cycle pulse
jump  out  1  jump request, one-cycle pulse
opcode  out  WIDTH_OPCODE  opcode of the held instruction (ir)
jdata  out  WIDTH_JDATA  operand of the held instruction (ir)
cmd_valid  out  1  command valid
cmd_ready  in  1  command accepted
cmd_data  out  WIDTH_JDATA  command payload
busy  out  1  state is not IDLE and not HALT
halted  out  1  state is HALT
error  out  1  sticky error flag

Behaviour:
- Reset, sampled on the clk edge while rstn=0:
  - state=IDLE; ir=0; loop_cnt=0; wait_cnt=0.
  - All outputs 0.
  - The memory shares rstn, so its address returns to 0 at the same time.
- States: IDLE, FETCH, DECODE, EXEC, CMD, WAIT, HALT.
- IDLE: start=1 moves to FETCH with lat_cnt=MEM_LAT. This first fetch issues no pulse and reads address 0.
- FETCH: lat_cnt decrements each cycle; at 1 moves to DECODE.
- DECODE: ir<=instr; moves to EXEC.
- opcode and jdata are always driven from ir.
- EXEC actions, decoded from ir's opcode:
  - 0000 NOP: next_instr=1 for one cycle, then FETCH.
  - 0001 CMD: go to CMD.
  - 0010 WAIT: if jdata=0, act as NOP; else wait_cnt<=jdata and go to WAIT.
  - 0011 LOOP: loop_cnt<=jdata[WIDTH_LOOP-1:0]; next_instr pulse; then FETCH.
  - 1001 DJNZ:
    - If loop_cnt>1: loop_cnt--, pulse jump (memory adds the offset, two's complement, modulo 2^WIDTH_ADDR, relative to the current address).
    - Else: loop_cnt<=0 and pulse next_instr.
    - Either way, then FETCH.
  - 1010 JMP: pulse jump; memory loads absolute jdata[WIDTH_ADDR-1:0]; then FETCH.
  - 1111 HALT: go to HALT; no pulse.
  - Any other opcode: error<=1, go to HALT.
- jump and next_instr are never high in the same cycle.
- Every transition into FETCH reloads lat_cnt=MEM_LAT.
- CMD state:
  - cmd_valid=1 and cmd_data=jdata, held stable until cmd_ready=1.
  - In the handshake cycle: next_instr=1; next cycle cmd_valid=0 and state is FETCH.
- WAIT state: wait_cnt decrements each cycle; when it reaches 1, pulse next_instr and go to FETCH. The state therefore lasts exactly jdata cycles.
- HALT state:
  - start=1 clears error, pulses next_instr (resume at the next address), goes to FETCH.
  - With no start, the state holds indefinitely.
- start in any state other than IDLE/HALT is ignored.
- A LOOP nested inside a loop body overwrites loop_cnt; there is a single counter and no stack.
- Reset mid-operation (e.g. during CMD or WAIT) aborts immediately: cmd_valid drops on the next cycle, no pulse is issued, counters clear.
- Per-instruction latency with MEM_LAT=2 is 4 cycles (FETCH×2, DECODE, EXEC), plus CMD/WAIT time.

Optional Feature:
- Macro: INSTR_SEQ_WDOG_EN.
- Defined: a WDOG_W-bit counter runs while in CMD with cmd_ready=0, and clears on handshake or when leaving CMD.
  - At count 2^WDOG_W-1, drop cmd_valid, set error=1 and go to HALT.
  - HALT+start then skips the command.
- Not defined: CMD waits for cmd_ready indefinitely; no counter logic is synthesised.

Test Plan:
1. Program NOP,NOP,HALT, MEM_LAT=2, start at cycle 0 -> next_instr high exactly at cycles 4 and 8; halted=1 from cycle 13; busy=0 from cycle 13; no jump pulses.
2. CMD with jdata=0x00ABCD, cmd_ready low 5 cycles then high -> cmd_valid high 6 cycles with cmd_data=0x00ABCD stable; single next_instr pulse in the handshake cycle.
3. LOOP 3; NOP; DJNZ offset 0xFF -> NOP executed 3 times; 2 jump pulses with opcode=1001 and jdata[7:0]=0xFF; then next_instr; loop_cnt=0.
4. WAIT 10 -> exactly 10 cycles in WAIT, then one next_instr pulse; WAIT 0 -> next_instr in the EXEC cycle, same as NOP.
5. JMP 0x000020 -> one jump pulse with opcode=1010 and jdata=0x000020; next decoded instr comes from address 0x20. Opcode 0101 -> error=1, halted=1; start -> error=0, next_instr pulse.
6. rstn=0 for one cycle while waiting in CMD (and, with INSTR_SEQ_WDOG_EN and WDOG_W=4, a separate run holding cmd_ready=0) -> reset case: next cycle cmd_valid=0, busy=0, error=0, state IDLE. Watchdog case: error=1 and halted after 15 stall cycles.
